sram2axi_lite: RTL and testbench

SRAM2AXI_LITE -- requirements
Module: sram2axi_lite

---
 rtl/sram2axi_lite_pkg.sv | 24 ++
 rtl/sram2axi_lite_if.sv | 52 +++++
 rtl/sram2axi_lite.sv | 116 +++++++++++
 tb/tb_sram2axi_lite.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram2axi_lite_pkg.sv
// Shared types and constants for the SRAM-style to AXI4-Lite bridge.
// FSM encoding and AXI response codes live here.
package sram2axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_err(input logic [1:0] r);
    return r != RESP_OKAY;
  endfunction

endpackage

// File: rtl/sram2axi_lite_if.sv
// AXI4-Lite channel bundle used between the bridge and its slave.
// The master modport is the bridge side.
interface sram2axi_lite_if #(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64
) ();

  logic                 awvalid;
  logic                 awready;
  logic [ADDR_WD-1:0]   awaddr;
  logic [2:0]           awprot;
  logic                 wvalid;
  logic                 wready;
  logic [DATA_WD-1:0]   wdata;
  logic [DATA_WD/8-1:0] wstrb;
  logic                 bvalid;
  logic                 bready;
  logic [1:0]           bresp;
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_WD-1:0]   araddr;
  logic [2:0]           arprot;
  logic                 rvalid;
  logic                 rready;
  logic [DATA_WD-1:0]   rdata;
  logic [1:0]           rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/sram2axi_lite.sv
// Bridges a single-outstanding SRAM-style request port onto AXI4-Lite.
// Request fields are captured on leaving IDLE; AXI is driven from the copy.
module sram2axi_lite
  import sram2axi_lite_pkg::*;
#(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_en,
  input  logic [DATA_WD/8-1:0] req_we,
  input  logic [ADDR_WD-1:0]   req_addr,
  input  logic [DATA_WD-1:0]   req_wdata,
  output logic [DATA_WD-1:0]   req_rdata,
  output logic                 stall,
  output logic                 done,
  output logic                 bus_err,
  sram2axi_lite_if.master      axi
);

  localparam int STRB_WD = DATA_WD / 8;

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_WD-1:0]   addr_q;
  logic [STRB_WD-1:0]   we_q;
  logic [DATA_WD-1:0]   wdata_q;
  logic                 aw_done_q;
  logic                 w_done_q;
  logic                 bus_err_q;
  logic [DATA_WD-1:0]   rdata_q;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 start;

  assign start = (state_q == IDLE) && req_en;

  assign axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign axi.bready  = (state_q == WR_RESP);
  assign axi.arvalid = (state_q == RD_REQ);
  assign axi.rready  = (state_q == RD_RESP);
  assign axi.awaddr  = addr_q;
  assign axi.araddr  = addr_q;
  assign axi.awprot  = PROT_DEFAULT;
  assign axi.arprot  = PROT_DEFAULT;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = we_q;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  assign stall     = req_en && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign bus_err   = (state_q == DONE) && bus_err_q;
  assign req_rdata = rdata_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: writes wait for both AW and W, in any order.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_en) begin
          if (req_we != '0) state_d = WR_REQ;
          else              state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
          state_d = WR_RESP;
      end
      WR_RESP: if (axi.bvalid) state_d = DONE;
      RD_REQ:  if (axi.arready) state_d = RD_RESP;
      RD_RESP: if (axi.rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, handshake tracking and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (start) begin
        addr_q    <= req_addr;
        we_q      <= req_we;
        wdata_q   <= req_wdata;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if ((state_q == WR_RESP) && axi.bvalid)
        bus_err_q <= resp_err(axi.bresp);
      if ((state_q == RD_RESP) && axi.rvalid) begin
        rdata_q   <= axi.rdata;
        bus_err_q <= resp_err(axi.rresp);
      end
    end
  end

endmodule

// File: tb/tb_sram2axi_lite.sv
// Directed bench for sram2axi_lite with an AXI4-Lite slave model
// and a scoreboard of expected completions.
module tb_sram2axi_lite;

  logic        clk;
  logic        rst;
  logic        req_en;
  logic [7:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] req_rdata;
  logic        stall;
  logic        done;
  logic        bus_err;

  sram2axi_lite_if #(.ADDR_WD(64), .DATA_WD(64)) axi ();

  sram2axi_lite #(.ADDR_WD(64), .DATA_WD(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_en    (req_en),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .stall     (stall),
    .done      (done),
    .bus_err   (bus_err),
    .axi       (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [63:0] addr;
    logic [7:0]  we;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Slave model configuration.
  int          aw_lat = 0;
  logic        hold_r = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;

  int          aw_cnt;
  logic        aw_got, w_got;
  logic        s_bvalid;
  logic [1:0]  s_bresp;
  logic        r_pend;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_aw_hs, s_w_hs;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_lat);
  assign axi.wready  = axi.wvalid;
  assign axi.arready = axi.arvalid;
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = s_bresp;
  assign axi.rvalid  = r_pend && !hold_r;
  assign axi.rdata   = s_rdata;
  assign axi.rresp   = s_rresp;
  assign s_aw_hs     = axi.awvalid && axi.awready;
  assign s_w_hs      = axi.wvalid && axi.wready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt   <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp  <= 2'b00;
      r_pend   <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= 2'b00;
    end else begin
      if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
      else                             aw_cnt <= 0;
      if (s_bvalid && axi.bready) begin
        s_bvalid <= 1'b0;
      end else if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        s_bvalid <= 1'b1;
        s_bresp  <= bresp_cfg;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (s_aw_hs) aw_got <= 1'b1;
        if (s_w_hs)  w_got  <= 1'b1;
      end
      if (axi.arvalid && axi.arready) begin
        r_pend  <= 1'b1;
        s_rdata <= rdata_cfg;
        s_rresp <= rresp_cfg;
      end else if (axi.rvalid && axi.rready) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Monitor: address/data checks on handshakes, scoreboard on done.
  int awv_cyc = 0;
  int wv_cyc  = 0;
  int ar_hs_n = 0;
  int done_n  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (axi.awvalid) awv_cyc++;
      if (axi.wvalid)  wv_cyc++;
      if (axi.arvalid && axi.arready) begin
        ar_hs_n++;
        if (sb.size() == 0) check("ar_no_exp", 1, 0);
        else begin
          check("araddr", axi.araddr, sb[0].addr);
          check("arprot", {61'd0, axi.arprot}, 0);
        end
      end
      if (axi.awvalid && axi.awready) begin
        if (sb.size() == 0) check("aw_no_exp", 1, 0);
        else begin
          check("awaddr", axi.awaddr, sb[0].addr);
          check("awprot", {61'd0, axi.awprot}, 0);
        end
      end
      if (axi.wvalid && axi.wready) begin
        if (sb.size() == 0) check("w_no_exp", 1, 0);
        else begin
          check("wstrb", {56'd0, axi.wstrb}, {56'd0, sb[0].we});
          check("wdata", axi.wdata, sb[0].wdata);
        end
      end
      if (done) begin
        done_n++;
        if (sb.size() == 0) check("done_no_exp", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("bus_err", {63'd0, bus_err}, {63'd0, e.err});
          if (e.rd) check("req_rdata", req_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_done(output int lat, output int st_bad,
                           input logic scramble, input logic [63:0] a);
    lat = -1;
    st_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (!stall) st_bad++;
      if (scramble && i == 1) req_addr = ~a;
    end
  endtask

  task automatic run_req(input string tag, input logic [7:0] we,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input logic [1:0] resp,
                         input logic scramble, input int exp_lat);
    exp_t e;
    int lat, st_bad;
    rdata_cfg = rd;
    bresp_cfg = resp;
    rresp_cfg = resp;
    e.rd = (we == 8'h00);
    e.addr = a;
    e.we = we;
    e.wdata = wd;
    e.rdata = rd;
    e.err = (resp != 2'b00);
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_en = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    wait_done(lat, st_bad, scramble, a);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_busy"}, st_bad, 0);
    check({tag, "_stall_done"}, {63'd0, stall}, 0);
    @(posedge clk);
    #1;
    req_en = 1'b0;
    req_we = '0;
    @(negedge clk);
    check({tag, "_done_1cyc"}, {63'd0, done}, 0);
  endtask

  initial begin
    int lat, st_bad, gap, dn0;
    exp_t e;
    rst = 1'b1;
    req_en = 1'b0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;

    // Reset state; stall still follows req_en.
    repeat (2) @(posedge clk);
    #1;
    req_en = 1'b1;
    @(negedge clk);
    check("rst_stall", {63'd0, stall}, 1);
    check("rst_done", {63'd0, done}, 0);
    check("rst_bus_err", {63'd0, bus_err}, 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_awvalid", {63'd0, axi.awvalid}, 0);
    check("rst_wvalid", {63'd0, axi.wvalid}, 0);
    check("rst_arvalid", {63'd0, axi.arvalid}, 0);
    check("rst_bready", {63'd0, axi.bready}, 0);
    check("rst_rready", {63'd0, axi.rready}, 0);
    req_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait read.
    run_req("rd0", 8'h00, 64'h8000_0010, 64'h0,
            64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 3);

    // Write with AW delayed three cycles, W immediate.
    aw_lat = 3;
    awv_cyc = 0;
    wv_cyc = 0;
    dn0 = done_n;
    run_req("wr_dly", 8'h0F, 64'h0000_1000, 64'h1122_3344_5566_7788,
            64'h0, 2'b00, 1'b0, 6);
    check("wr_dly_awv_cyc", awv_cyc, 4);
    check("wr_dly_wv_cyc", wv_cyc, 1);
    check("wr_dly_done_n", done_n - dn0, 1);
    aw_lat = 0;

    // SLVERR write, then OKAY read clears the error.
    run_req("wr_err", 8'hFF, 64'h0000_2000, 64'hA5A5_5A5A_0F0F_F0F0,
            64'h0, 2'b10, 1'b0, 3);
    run_req("rd_ok", 8'h00, 64'h0000_2008, 64'h0,
            64'h0123_4567_89AB_CDEF, 2'b00, 1'b0, 3);

    // DECERR read still captures data; a later write leaves it held.
    run_req("rd_dec", 8'h00, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,
            64'hCAFE_F00D_1234_5678, 2'b11, 1'b0, 3);
    run_req("wr_hold", 8'h80, 64'h0000_3000, 64'hFF00_0000_0000_0000,
            64'h0, 2'b00, 1'b0, 3);
    check("rdata_held", req_rdata, 64'hCAFE_F00D_1234_5678);

    // Address changes while stalled must be ignored.
    run_req("wr_scr", 8'h3C, 64'h0000_4440, 64'h0BAD_0BAD_0BAD_0BAD,
            64'h0, 2'b00, 1'b1, 3);
    run_req("rd_scr", 8'h00, 64'h0000_5550, 64'h0,
            64'h7777_6666_5555_4444, 2'b00, 1'b1, 3);

    // Back-to-back reads with req_en held.
    ar_hs_n = 0;
    dn0 = done_n;
    rdata_cfg = 64'h1111_2222_3333_4444;
    rresp_cfg = 2'b00;
    e.rd = 1'b1; e.we = '0; e.wdata = '0; e.err = 1'b0;
    e.addr = 64'h0000_6000; e.rdata = 64'h1111_2222_3333_4444;
    sb.push_back(e);
    e.addr = 64'h0000_6008; e.rdata = 64'h9999_8888_7777_6666;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_en = 1'b1;
    req_we = '0;
    req_addr = 64'h0000_6000;
    wait_done(lat, st_bad, 1'b0, 64'h0);
    check("b2b_lat1", lat, 3);
    @(posedge clk);
    #1;
    req_addr = 64'h0000_6008;
    rdata_cfg = 64'h9999_8888_7777_6666;
    gap = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.arvalid) begin
        gap = i;
        break;
      end
    end
    check("b2b_idle_cycles", gap, 1);
    wait_done(lat, st_bad, 1'b0, 64'h0);
    check("b2b_lat2", lat, 1);
    @(posedge clk);
    #1;
    req_en = 1'b0;
    @(negedge clk);
    check("b2b_ar_hs", ar_hs_n, 2);
    check("b2b_done_n", done_n - dn0, 2);

    // Reset during RD_RESP with rvalid held low.
    hold_r = 1'b1;
    e.addr = 64'h0000_7000; e.rdata = 64'h0; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_en = 1'b1;
    req_addr = 64'h0000_7000;
    gap = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.rready) begin
        gap = i;
        break;
      end
    end
    check("rst_mid_reach_resp", {63'd0, gap >= 0}, 1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    dn0 = done_n;
    check("rst_mid_rready", {63'd0, axi.rready}, 0);
    check("rst_mid_arvalid", {63'd0, axi.arvalid}, 0);
    check("rst_mid_done", {63'd0, done}, 0);
    check("rst_mid_rdata", req_rdata, 0);
    check("rst_mid_stall", {63'd0, stall}, 1);
    req_en = 1'b0;
    hold_r = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", {63'd0, done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_pulse", done_n - dn0, 0);
    run_req("rd_after_rst", 8'h00, 64'h0000_7000, 64'h0,
            64'h5555_AAAA_5555_AAAA, 2'b00, 1'b0, 3);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
